// File: rtl/conv_accumulator_pkg.sv
// Shared header for the convolver datapath.
// Holds the datapath widths used across the convolver stages and the
// saturating-add overflow helper used by the channel accumulator.
package conv_accumulator_pkg;

  // Existing convolver widths (pixel and coefficient operands).
  localparam int WID_PIX      = 8;
  localparam int WID_COEF     = 8;

  // Multiplier product, accumulator/output and channel-count widths.
  // WID_ACC must be at least WID_MAC_MULT+4 so that the nine-input sum
  // can never wrap inside the adder tree.
  localparam int WID_MAC_MULT = 16;
  localparam int WID_ACC      = 24;
  localparam int WID_CH       = 8;

  // Number of products in one 3x3 window.
  localparam int N_TAPS       = 9;

  // Overflow classification for a two's-complement add of equal-width
  // operands. Only the sign bits are needed, so the helper works for any
  // width. Returns {pos_ovf, neg_ovf}: the wrapped sum must be replaced
  // by the positive or negative rail respectively.
  function automatic logic [1:0] sat_add_ovf(
    input logic a_msb_i,
    input logic b_msb_i,
    input logic sum_msb_i
  );
    logic [1:0] ovf_s;
    ovf_s = 2'b00;
    if ((a_msb_i == b_msb_i) && (sum_msb_i != a_msb_i)) begin
      if (a_msb_i == 1'b0) begin
        ovf_s = 2'b10;
      end else begin
        ovf_s = 2'b01;
      end
    end else begin
      ovf_s = 2'b00;
    end
    return ovf_s;
  endfunction

endpackage

// File: rtl/conv_accumulator_add_tree.sv
// conv_add_tree: two-level registered reduction of the nine window products.
// Level 1 sums three groups of three sign-extended products, level 2 sums
// the three partial sums. Both levels advance only on en_i; clear_i empties
// the pipeline (valid bits and partial sums) with priority over en_i.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   en_i               pipeline advance enable
//   clear_i            synchronous flush
//   valid_i            beat valid entering level 1
//   prod_i[k]          signed product k (k=0 is p1)
//   valid_o, sum_o     level-2 valid and window sum (WID_OUT bits, signed)
module conv_add_tree
  import conv_accumulator_pkg::*;
#(
  parameter int WID_IN  = 16,
  parameter int WID_OUT = 24
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            en_i,
  input  logic                            clear_i,
  input  logic                            valid_i,
  input  logic [N_TAPS-1:0][WID_IN-1:0]   prod_i,
  output logic                            valid_o,
  output logic [WID_OUT-1:0]              sum_o
);

  logic [N_TAPS-1:0][WID_OUT-1:0] ext_s;
  logic [WID_OUT-1:0] s_a_q, s_a_d, s_b_q, s_b_d, s_c_q, s_c_d;
  logic [WID_OUT-1:0] tsum_q, tsum_d;
  logic               v1_q, v1_d, v2_q, v2_d;

  // Sign-extend every product to the accumulator width; two's-complement
  // addition then needs no further sign handling.
  always_comb begin
    ext_s = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      ext_s[k] = {{(WID_OUT-WID_IN){prod_i[k][WID_IN-1]}}, prod_i[k]};
    end
  end

  // Next state of both tree levels: flush, advance or hold.
  always_comb begin
    s_a_d  = s_a_q;
    s_b_d  = s_b_q;
    s_c_d  = s_c_q;
    v1_d   = v1_q;
    tsum_d = tsum_q;
    v2_d   = v2_q;
    if (clear_i) begin
      s_a_d  = '0;
      s_b_d  = '0;
      s_c_d  = '0;
      v1_d   = 1'b0;
      tsum_d = '0;
      v2_d   = 1'b0;
    end else if (en_i) begin
      s_a_d  = ext_s[0] + ext_s[1] + ext_s[2];
      s_b_d  = ext_s[3] + ext_s[4] + ext_s[5];
      s_c_d  = ext_s[6] + ext_s[7] + ext_s[8];
      v1_d   = valid_i;
      tsum_d = s_a_q + s_b_q + s_c_q;
      v2_d   = v1_q;
    end else begin
      v1_d   = v1_q;
      v2_d   = v2_q;
    end
  end

  // Tree pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_a_q  <= '0;
      s_b_q  <= '0;
      s_c_q  <= '0;
      v1_q   <= 1'b0;
      tsum_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      s_a_q  <= s_a_d;
      s_b_q  <= s_b_d;
      s_c_q  <= s_c_d;
      v1_q   <= v1_d;
      tsum_q <= tsum_d;
      v2_q   <= v2_d;
    end
  end

  assign valid_o = v2_q;
  assign sum_o   = tsum_q;

endmodule

// File: rtl/conv_accumulator.sv
// conv_accumulator: reduces the nine 3x3 window products per beat through a
// registered adder tree, accumulates the window sums over num_ch channels
// with saturation, and hands one result per channel group downstream.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   clear_i                     synchronous flush of pipeline and partial group
//   in_valid_i / in_ready_o     product beat handshake
//   p1_i .. p9_i                signed window products
//   num_ch_i                    channels per output pixel (0 means 1)
//   out_valid_o / out_ready_i   result handshake
//   out_data_o                  signed saturated result
module conv_accumulator #(
  parameter int WID_MAC_MULT = conv_accumulator_pkg::WID_MAC_MULT,
  parameter int WID_ACC      = conv_accumulator_pkg::WID_ACC,
  parameter int WID_CH       = conv_accumulator_pkg::WID_CH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WID_MAC_MULT-1:0] p1_i,
  input  logic [WID_MAC_MULT-1:0] p2_i,
  input  logic [WID_MAC_MULT-1:0] p3_i,
  input  logic [WID_MAC_MULT-1:0] p4_i,
  input  logic [WID_MAC_MULT-1:0] p5_i,
  input  logic [WID_MAC_MULT-1:0] p6_i,
  input  logic [WID_MAC_MULT-1:0] p7_i,
  input  logic [WID_MAC_MULT-1:0] p8_i,
  input  logic [WID_MAC_MULT-1:0] p9_i,
  input  logic [WID_CH-1:0]       num_ch_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WID_ACC-1:0]      out_data_o
);
  import conv_accumulator_pkg::*;

  localparam logic [WID_CH-1:0]  CH_ONE  = {{(WID_CH-1){1'b0}}, 1'b1};
  localparam logic [WID_ACC-1:0] ACC_MAX = {1'b0, {(WID_ACC-1){1'b1}}};
  localparam logic [WID_ACC-1:0] ACC_MIN = {1'b1, {(WID_ACC-1){1'b0}}};

  logic [N_TAPS-1:0][WID_MAC_MULT-1:0] prod_s;
  logic                 en_s, v2_s;
  logic [WID_ACC-1:0]   tsum_s, acc_raw_s, acc_new_s;
  logic [1:0]           ovf_s;
  logic                 first_s;
  logic [WID_CH-1:0]    nc_eff_s;

  logic [WID_CH-1:0]    ch_cnt_q, ch_cnt_d;
  logic [WID_CH-1:0]    num_ch_q, num_ch_d;
  logic [WID_ACC-1:0]   acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [WID_ACC-1:0]   out_data_q, out_data_d;

  // A result held without downstream acceptance freezes the whole pipe.
  assign en_s       = !(out_valid_q && !out_ready_i);
  assign in_ready_o = en_s;
  assign prod_s     = {p9_i, p8_i, p7_i, p6_i, p5_i, p4_i, p3_i, p2_i, p1_i};

  conv_add_tree #(
    .WID_IN  (WID_MAC_MULT),
    .WID_OUT (WID_ACC)
  ) u_add_tree (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (en_s),
    .clear_i (clear_i),
    .valid_i (in_valid_i),
    .prod_i  (prod_s),
    .valid_o (v2_s),
    .sum_o   (tsum_s)
  );

  // Candidate accumulator value: a group's first beat loads the window sum,
  // later beats add with clamping to the signed rails.
  always_comb begin
    first_s   = (ch_cnt_q == '0);
    nc_eff_s  = (num_ch_i == '0) ? CH_ONE : num_ch_i;
    acc_raw_s = acc_q + tsum_s;
    ovf_s     = sat_add_ovf(acc_q[WID_ACC-1], tsum_s[WID_ACC-1], acc_raw_s[WID_ACC-1]);
    if (first_s) begin
      acc_new_s = tsum_s;
    end else begin
      case (ovf_s)
        2'b10:   acc_new_s = ACC_MAX;
        2'b01:   acc_new_s = ACC_MIN;
        default: acc_new_s = acc_raw_s;
      endcase
    end
    // The terminal-count compare on a first beat uses the channel count
    // being latched in the same cycle.
    if (!first_s) begin
      nc_eff_s = num_ch_q;
    end else begin
      nc_eff_s = nc_eff_s;
    end
  end

  // Accumulator, channel counter and output register next state.
  always_comb begin
    ch_cnt_d    = ch_cnt_q;
    num_ch_d    = num_ch_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clear_i) begin
      ch_cnt_d    = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end else if (en_s) begin
      // Advancing implies any held result is taken this cycle.
      out_valid_d = 1'b0;
      if (v2_s) begin
        acc_d    = acc_new_s;
        num_ch_d = first_s ? nc_eff_s : num_ch_q;
        if (ch_cnt_q == (nc_eff_s - CH_ONE)) begin
          out_data_d  = acc_new_s;
          out_valid_d = 1'b1;
          ch_cnt_d    = '0;
        end else begin
          ch_cnt_d    = ch_cnt_q + CH_ONE;
        end
      end else begin
        ch_cnt_d = ch_cnt_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Accumulate-stage and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ch_cnt_q    <= '0;
      num_ch_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      num_ch_q    <= num_ch_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Self-checking bench for conv_accumulator: directed scenarios with literal
// expectations plus randomized traffic against a group-level reference model.
module tb_conv_accumulator;
  localparam int WM = 16;
  localparam int WA = 24;
  localparam int WC = 8;

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid, in_ready, out_valid, out_ready;
  logic [WM-1:0] p_s [9];
  logic [WC-1:0] num_ch;
  logic [WA-1:0] out_data;

  always #5 clk = ~clk;

  conv_accumulator #(.WID_MAC_MULT(WM), .WID_ACC(WA), .WID_CH(WC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .p1_i(p_s[0]), .p2_i(p_s[1]), .p3_i(p_s[2]), .p4_i(p_s[3]), .p5_i(p_s[4]),
    .p6_i(p_s[5]), .p7_i(p_s[6]), .p8_i(p_s[7]), .p9_i(p_s[8]),
    .num_ch_i(num_ch), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data)
  );

  int      tests = 0;
  int      fails = 0;
  longint  cyc = 0;
  longint  exp_q[$];
  longint  got_q[$];
  int      grp_cnt = 0;
  int      grp_n = 1;
  longint  grp_acc = 0;
  bit      saw_ready_low = 1'b0;
  longint  accept_cyc = 0;
  longint  first_valid_cyc = -1;
  int      valid_cycles = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (WA - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  // Reference model and compare process, evaluated mid-cycle.
  initial begin
    longint sum;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        grp_cnt = 0;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", longint'($signed(out_data)), 0);
      end else begin
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (!in_ready) saw_ready_low = 1'b1;
        if (out_valid) begin
          valid_cycles++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %0d, expected no result (cycle %0d)",
                     longint'($signed(out_data)), cyc);
          end else begin
            check("out_data", longint'($signed(out_data)), exp_q[0]);
            if (out_ready) begin
              got_q.push_back(longint'($signed(out_data)));
              void'(exp_q.pop_front());
            end
          end
        end
        if (clear) begin
          // Everything not yet handed downstream is lost.
          exp_q.delete();
          grp_cnt = 0;
        end else if (in_valid && in_ready) begin
          sum = 0;
          for (int i = 0; i < 9; i++) sum += longint'($signed(p_s[i]));
          accept_cyc = cyc;
          if (grp_cnt == 0) begin
            grp_n   = (num_ch == 0) ? 1 : int'(num_ch);
            grp_acc = sum;
          end else begin
            grp_acc = clamp(grp_acc + sum);
          end
          grp_cnt++;
          if (grp_cnt == grp_n) begin
            exp_q.push_back(grp_acc);
            grp_cnt = 0;
          end
        end
      end
    end
  end

  task automatic set_all(input longint v);
    for (int i = 0; i < 9; i++) p_s[i] = WM'(v);
  endtask

  task automatic send();
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || n < 5) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_list(input string name, input int n,
                            input longint e0, input longint e1,
                            input longint e2, input longint e3);
    longint e [4];
    e = '{e0, e1, e2, e3};
    check({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) check($sformatf("%s_%0d", name, i), got_q[i], e[i]);
    end
  endtask

  task automatic start_test();
    got_q.delete();
    valid_cycles = 0;
    first_valid_cyc = -1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; num_ch = 8'd1;
    set_all(0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat, one channel: 1+2+...+9.
    start_test();
    num_ch = 8'd1;
    for (int i = 0; i < 9; i++) p_s[i] = WM'(i + 1);
    send();
    drain();
    check_list("t1", 1, 45, 0, 0, 0);
    check("t1_latency", first_valid_cyc - accept_cyc, 3);
    check("t1_valid_cycles", valid_cycles, 1);

    // Three channels back to back: 9 + 18 - 9.
    start_test();
    num_ch = 8'd3;
    set_all(1); send();
    set_all(2); send();
    set_all(-1); send();
    drain();
    check_list("t2", 1, 18, 0, 0, 0);
    check("t2_valid_cycles", valid_cycles, 1);

    // Backpressure: downstream stalls 5 cycles on the first result.
    start_test();
    num_ch = 8'd1;
    saw_ready_low = 1'b0;
    fork
      begin
        set_all(1); send();
        set_all(2); send();
        set_all(3); send();
        set_all(4); send();
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_list("t3", 4, 9, 18, 27, 36);
    check("t3_in_ready_dropped", saw_ready_low, 1);

    // Saturation to both rails over 255 channels.
    start_test();
    num_ch = 8'd255;
    set_all(32767);
    repeat (255) send();
    set_all(-32768);
    repeat (255) send();
    drain();
    check_list("t4", 2, 8388607, -8388608, 0, 0);

    // Clear mid-group; the beat presented with clear is dropped.
    start_test();
    num_ch = 8'd4;
    set_all(5); send(); send();
    set_all(7);
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    set_all(1);
    repeat (4) send();
    drain();
    check_list("t5", 1, 36, 0, 0, 0);

    // num_ch of zero acts as one.
    start_test();
    num_ch = 8'd0;
    set_all(2); send();
    drain();
    check_list("t6a", 1, 18, 0, 0, 0);

    // num_ch changed 4 -> 2 after the group's first beat is counted.
    start_test();
    num_ch = 8'd4;
    set_all(1); send();
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    num_ch = 8'd2;
    repeat (3) send();
    drain();
    check_list("t6b", 1, 36, 0, 0, 0);
    check("t6b_valid_cycles", valid_cycles, 1);

    // Randomized traffic; num_ch changes only while the tree is empty.
    for (int seg = 0; seg < 12; seg++) begin
      bit big;
      bit neg;
      drain();
      big = (seg % 4 == 3);
      neg = $urandom_range(0, 1) == 1;
      num_ch = big ? WC'($urandom_range(30, 80)) : WC'($urandom_range(0, 5));
      for (int c = 0; c < 200; c++) begin
        in_valid  = $urandom_range(0, 3) != 0;
        out_ready = $urandom_range(0, 9) < 7;
        clear     = $urandom_range(0, 99) == 0;
        for (int i = 0; i < 9; i++) begin
          if (big) p_s[i] = neg ? WM'(-longint'($urandom_range(30000, 32768)))
                                : WM'($urandom_range(30000, 32767));
          else     p_s[i] = WM'($urandom);
        end
        if (seg == 5 && c == 100) rst_n = 1'b0;
        else rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      rst_n = 1'b1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
